// File: rtl/datapath_pkg.sv
// Shared types for the datapath: ALU operation codes, multiply/divide
// operation codes and the multiply/divide sequencer states.
package datapath_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_t;

   typedef enum logic [1:0] {
      MD_MUL   = 2'b00,
      MD_MULHU = 2'b01,
      MD_DIVU  = 2'b10,
      MD_REMU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_DONE = 2'b10
   } md_state_t;

endpackage

// File: rtl/datapath_md_if.sv
// Controller <-> datapath bundle. The controller side (master) drives the
// register indices, operand/control selects, memory read data and the
// multiply/divide start; the datapath side (slave) returns flags, addresses,
// store data and the multiply/divide status.
// MD handshake: MDStart is sampled only while Busy=0; once accepted, Busy
// stays high until the result is written, Done pulses for exactly the final
// Busy cycle, and the controller must hold off RegWrite while Busy=1.
interface datapath_md_if
   import datapath_pkg::*;
#(
   parameter int NBITS      = 32,
   parameter int NREGS      = 32,
   parameter int WIDTH_ALUF = 4
);
   localparam int RW = $clog2(NREGS);

   logic [RW-1:0]         RS1, RS2, RD;
   logic signed [NBITS-1:0] IMM;
   logic [WIDTH_ALUF-1:0] ALUControl;
   logic                  ALUSrc, MemtoReg, RegWrite, link;
   logic [NBITS-1:0]      pclink;
   logic                  MDStart;
   logic [1:0]            MDOp;
   logic                  Busy, Done;
   logic                  Zero, Neg, Carry;
   logic [NBITS-1:0]      PCReg;
   logic [NBITS-3:0]      Address;
   logic [NBITS-1:0]      WriteData;
   logic [NBITS-1:0]      ReadData;
   md_state_t             md_state;

   modport master (
      output RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite, link,
             pclink, MDStart, MDOp, ReadData,
      input  Busy, Done, Zero, Neg, Carry, PCReg, Address, WriteData, md_state
   );

   modport slave (
      input  RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite, link,
             pclink, MDStart, MDOp, ReadData,
      output Busy, Done, Zero, Neg, Carry, PCReg, Address, WriteData, md_state
   );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide, one bit per clock. hi/lo form a
// 2*NBITS working register: for multiply it is {partial product, multiplier},
// for divide it is {partial remainder, dividend/quotient}.
module muldiv_seq
   import datapath_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int RW    = 5
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  md_op_t           op,
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic [RW-1:0]    rd_in,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] result,
   output logic [RW-1:0]    rd_out,
   output md_state_t        state
);
   localparam int CW = $clog2(NBITS);

   md_state_t        state_q, state_d;
   logic [CW-1:0]    count_q;
   logic [NBITS-1:0] hi_q, lo_q, b_q;
   logic [NBITS-1:0] hi_step, lo_step;
   md_op_t           op_q;
   logic [RW-1:0]    rd_q;
   logic [NBITS:0]   mul_sum, rem_shift;
   logic [NBITS-1:0] rem_diff;
   logic             rem_ge;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= MD_IDLE;
      else        state_q <= state_d;
   end

   // Next state: accept start only when idle, leave RUN after the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start) state_d = MD_RUN;
         MD_RUN:  if (count_q == '0) state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // One iteration: shift-add for multiply, restoring subtract for divide.
   // A zero divisor always "fits", so the quotient fills with ones and the
   // remainder ends up equal to the dividend with no special case.
   always_comb begin
      hi_step   = hi_q;
      lo_step   = lo_q;
      mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
      rem_shift = {hi_q, lo_q[NBITS-1]};
      rem_diff  = rem_shift[NBITS-1:0] - b_q;
      rem_ge    = (rem_shift >= {1'b0, b_q});
      if (op_q == MD_DIVU || op_q == MD_REMU) begin
         hi_step = rem_ge ? rem_diff : rem_shift[NBITS-1:0];
         lo_step = {lo_q[NBITS-2:0], rem_ge};
      end else begin
         hi_step = mul_sum[NBITS:1];
         lo_step = {mul_sum[0], lo_q[NBITS-1:1]};
      end
   end

   // Operand latch on start, then one step per RUN cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         op_q    <= MD_MUL;
         rd_q    <= '0;
      end else begin
         case (state_q)
            MD_IDLE: if (start) begin
               hi_q    <= '0;
               lo_q    <= a;
               b_q     <= b;
               op_q    <= op;
               rd_q    <= rd_in;
               count_q <= CW'(NBITS - 1);
            end
            MD_RUN: begin
               hi_q    <= hi_step;
               lo_q    <= lo_step;
               count_q <= count_q - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result select: high half for MULHU/REMU, low half for MUL/DIVU.
   always_comb begin
      case (op_q)
         MD_MULHU, MD_REMU: result = hi_q;
         default:           result = lo_q;
      endcase
   end

   assign busy   = (state_q != MD_IDLE);
   assign done   = (state_q == MD_DONE);
   assign rd_out = rd_q;
   assign state  = state_q;

endmodule

// File: rtl/datapath_md.sv
// Datapath: register file, integer ALU with flags, writeback mux and the
// iterative multiply/divide unit. The MD writeback owns the register write
// port in its DONE cycle, so a coincident RegWrite is dropped.
module datapath_md
   import datapath_pkg::*;
#(
   parameter int NBITS      = 32,
   parameter int NREGS      = 32,
   parameter int WIDTH_ALUF = 4
)
(
   input logic          clock,
   input logic          reset,
   datapath_md_if.slave dp
);
   localparam int RW = $clog2(NREGS);
   localparam int SW = $clog2(NBITS);

   logic [NBITS-1:0]      regs [NREGS];
   logic [NBITS-1:0]      src_a, src_b, rs2_val, alu_result, wb_result, md_result;
   logic [NBITS:0]        add_full, sub_full;
   logic [SW-1:0]         shamt;
   logic [WIDTH_ALUF-1:0] alu_ctl;
   logic                  alu_carry, md_done;
   logic [RW-1:0]         md_rd;
   logic                  wr_en;
   logic [RW-1:0]         wr_idx;
   logic [NBITS-1:0]      wr_data;

   assign src_a    = (dp.RS1 == '0) ? '0 : regs[dp.RS1];
   assign rs2_val  = (dp.RS2 == '0) ? '0 : regs[dp.RS2];
   assign src_b    = dp.ALUSrc ? dp.IMM : rs2_val;
   assign shamt    = src_b[SW-1:0];
   assign alu_ctl  = dp.ALUControl;
   assign add_full = {1'b0, src_a} + {1'b0, src_b};
   assign sub_full = {1'b0, src_a} - {1'b0, src_b};

   // ALU; unlisted codes (including ADD itself) fall through to add with carry.
   always_comb begin
      alu_result = add_full[NBITS-1:0];
      alu_carry  = add_full[NBITS];
      case (alu_ctl)
         ALU_SUB: begin
            alu_result = sub_full[NBITS-1:0];
            alu_carry  = ~sub_full[NBITS];
         end
         ALU_SLT: begin
            alu_result = {{(NBITS-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            alu_carry  = 1'b0;
         end
         ALU_SLTU: begin
            alu_result = {{(NBITS-1){1'b0}}, (src_a < src_b)};
            alu_carry  = 1'b0;
         end
         ALU_XOR: begin alu_result = src_a ^ src_b;            alu_carry = 1'b0; end
         ALU_OR:  begin alu_result = src_a | src_b;            alu_carry = 1'b0; end
         ALU_AND: begin alu_result = src_a & src_b;            alu_carry = 1'b0; end
         ALU_SLL: begin alu_result = src_a << shamt;           alu_carry = 1'b0; end
         ALU_SRL: begin alu_result = src_a >> shamt;           alu_carry = 1'b0; end
         ALU_SRA: begin alu_result = $signed(src_a) >>> shamt; alu_carry = 1'b0; end
         default: ;
      endcase
   end

   assign dp.Zero      = (alu_result == '0);
   assign dp.Neg       = alu_result[NBITS-1];
   assign dp.Carry     = alu_carry;
   assign dp.PCReg     = src_a;
   assign dp.WriteData = rs2_val;
   assign dp.Address   = alu_result[NBITS-1:2];
   assign dp.Done      = md_done;

   assign wb_result = dp.MemtoReg ? dp.ReadData : (dp.link ? dp.pclink : alu_result);

   // Write port arbitration: the MD result takes the port in its DONE cycle.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = dp.RD;
      wr_data = wb_result;
      if (md_done) begin
         wr_en   = (md_rd != '0);
         wr_idx  = md_rd;
         wr_data = md_result;
      end else if (dp.RegWrite && dp.RD != '0) begin
         wr_en = 1'b1;
      end
   end

   // Register file; entry 0 is never written and reads are forced to zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

   muldiv_seq #(.NBITS(NBITS), .RW(RW)) u_muldiv (
      .clock  (clock),
      .reset  (reset),
      .start  (dp.MDStart),
      .op     (md_op_t'(dp.MDOp)),
      .a      (src_a),
      .b      (rs2_val),
      .rd_in  (dp.RD),
      .busy   (dp.Busy),
      .done   (md_done),
      .result (md_result),
      .rd_out (md_rd),
      .state  (dp.md_state)
   );

endmodule

// File: tb/tb_datapath_md.sv
// Bench for datapath_md: directed cases plus randomized ALU and MD traffic,
// checked against a register-array model using plain arithmetic.
module tb_datapath_md;
   import datapath_pkg::*;

   logic clock, reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] m_regs [32];

   datapath_md_if #(.NBITS(32), .NREGS(32), .WIDTH_ALUF(4)) dp ();

   datapath_md #(.NBITS(32), .NREGS(32), .WIDTH_ALUF(4)) dut (
      .clock (clock),
      .reset (reset),
      .dp    (dp)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [32:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        c;
      int          sh;
      sh = int'(b % 32);
      c  = 1'b0;
      case (ctl)
         4'b1000: begin r = a - b; c = (a >= b); end
         4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: r = (a < b) ? 32'd1 : 32'd0;
         4'b0100: r = a ^ b;
         4'b0110: r = a | b;
         4'b0111: r = a & b;
         4'b0001: r = a << sh;
         4'b0101: r = a >> sh;
         4'b1101: r = $signed(a) >>> sh;
         default: begin
            r = a + b;
            c = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
         end
      endcase
      return {c, r};
   endfunction

   function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_in();
      dp.RS1 = '0; dp.RS2 = '0; dp.RD = '0; dp.IMM = '0;
      dp.ALUControl = '0; dp.ALUSrc = 1'b0; dp.MemtoReg = 1'b0;
      dp.RegWrite = 1'b0; dp.link = 1'b0; dp.pclink = '0;
      dp.MDStart = 1'b0; dp.MDOp = '0; dp.ReadData = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   task automatic read_reg(input int idx, output logic [31:0] v);
      dp.RegWrite = 1'b0;
      dp.MDStart  = 1'b0;
      dp.RS1      = 5'(idx);
      #1;
      v = dp.PCReg;
      @(negedge clock);
   endtask

   task automatic load_reg(input int rd, input logic [31:0] val);
      idle_in();
      dp.RD = 5'(rd); dp.IMM = val; dp.ALUSrc = 1'b1;
      dp.ALUControl = 4'b0000; dp.RegWrite = 1'b1;
      tick();
      idle_in();
      if (rd != 0) m_regs[rd] = val;
   endtask

   task automatic drive_alu(input logic [3:0] ctl, input int rs1, input int rs2, input logic alusrc,
                            input logic [31:0] imm, input int rd, input logic we);
      idle_in();
      dp.ALUControl = ctl; dp.RS1 = 5'(rs1); dp.RS2 = 5'(rs2);
      dp.ALUSrc = alusrc; dp.IMM = imm; dp.RD = 5'(rd); dp.RegWrite = we;
      #1;
   endtask

   // Starts an MD op and follows it to completion, optionally re-asserting
   // MDStart while busy and colliding a RegWrite in the Done cycle.
   task automatic run_md(input logic [1:0] op, input int rs1, input int rs2, input int rd,
                         input bit restart, input bit collide, input int col_rd, input logic [31:0] col_imm,
                         output int busy_n, output int done_n, output int done_at,
                         output logic [31:0] pre_val, output logic [31:0] post_val, output bit timed_out);
      idle_in();
      dp.MDStart = 1'b1; dp.MDOp = op; dp.RS1 = 5'(rs1); dp.RS2 = 5'(rs2); dp.RD = 5'(rd);
      tick();
      busy_n = 0; done_n = 0; done_at = 0; pre_val = '0; post_val = '0; timed_out = 1'b1;
      dp.RS1 = 5'(rd);
      for (int k = 0; k < 60; k++) begin
         dp.RegWrite = 1'b0;
         dp.MDStart  = restart;
         if (restart) begin dp.MDOp = 2'd2; dp.RD = 5'd7; end
         #1;
         if (!dp.Busy) begin
            dp.MDStart = 1'b0;
            post_val   = dp.PCReg;
            timed_out  = 1'b0;
            break;
         end
         busy_n++;
         if (dp.Done) begin
            done_n++;
            done_at = busy_n;
            pre_val = dp.PCReg;
            if (collide) begin
               dp.RegWrite = 1'b1; dp.RD = 5'(col_rd); dp.IMM = col_imm;
               dp.ALUSrc = 1'b1; dp.ALUControl = 4'b0000;
            end
         end
         tick();
      end
      idle_in();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_in();
      reset = 1'b0;
      model_clear();
      @(negedge clock);
      @(negedge clock);
      dp.RS1 = 5'd17; dp.RS2 = 5'd9;
      #1;
      checks++; if (dp.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dp.Busy); end
      checks++; if (dp.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", dp.Done); end
      checks++; if (dp.md_state !== MD_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dp.md_state, MD_IDLE); end
      checks++; if (dp.PCReg !== 32'd0) begin errors++; $display("FAIL reset_pcreg: got %h expected 0", dp.PCReg); end
      checks++; if (dp.WriteData !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", dp.WriteData); end
      checks++; if (dp.Zero !== 1'b1 || dp.Carry !== 1'b0) begin errors++; $display("FAIL reset_flags: got Z%b C%b expected Z1 C0", dp.Zero, dp.Carry); end
      reset = 1'b1;
      @(negedge clock);
      idle_in();
   endtask

   task automatic test_reset_midrun();
      logic [31:0] v;
      int seen;
      load_reg(5, 32'd7);
      load_reg(1, 32'd3);
      load_reg(2, 32'd4);
      read_reg(5, v);
      checks++; if (v !== 32'd7) begin errors++; $display("FAIL midrun_preload: got %h expected 7", v); end
      idle_in();
      dp.MDStart = 1'b1; dp.MDOp = 2'd0; dp.RS1 = 5'd1; dp.RS2 = 5'd2; dp.RD = 5'd5;
      tick();
      dp.MDStart = 1'b0;
      tick(); tick();
      #1;
      checks++; if (dp.Busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", dp.Busy); end
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      #1;
      checks++; if (dp.Busy !== 1'b0 || dp.Done !== 1'b0) begin errors++; $display("FAIL midrun_abort: got busy %b done %b expected 0 0", dp.Busy, dp.Done); end
      tick();
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 36; k++) begin
         tick();
         #1;
         if (dp.Busy || dp.Done) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_quiet: got %0d busy/done cycles expected 0", seen); end
      @(negedge clock);
      read_reg(5, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL midrun_x5: got %h expected 0", v); end
      read_reg(1, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL midrun_x1: got %h expected 0", v); end
   endtask

   task automatic test_alu_directed();
      logic [3:0]  ctls [5];
      logic        srcs [5];
      logic [31:0] imms [5];
      logic [31:0] exps [5];
      logic [31:0] v;
      ctls = '{4'b0000, 4'b0010, 4'b0011, 4'b1101, 4'b0101};
      srcs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      imms = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd4};
      exps = '{32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0FFF_FFFF};
      load_reg(1, 32'hFFFF_FFFF);
      load_reg(2, 32'd1);
      for (int i = 0; i < 5; i++) begin
         drive_alu(ctls[i], 1, 2, srcs[i], imms[i], 3, 1'b1);
         if (i == 0) begin
            checks++; if (dp.Zero !== 1'b1 || dp.Carry !== 1'b1) begin errors++; $display("FAIL add_flags: got Z%b C%b expected Z1 C1", dp.Zero, dp.Carry); end
         end
         if (i == 3) begin
            checks++; if (dp.Neg !== 1'b1 || dp.Carry !== 1'b0) begin errors++; $display("FAIL sra_flags: got N%b C%b expected N1 C0", dp.Neg, dp.Carry); end
         end
         tick();
         m_regs[3] = exps[i];
         read_reg(3, v);
         checks++; if (v !== exps[i]) begin errors++; $display("FAIL alu_dir op%h: got %h expected %h", ctls[i], v, exps[i]); end
      end
   endtask

   task automatic test_alu_random();
      logic [31:0] v, a, b, imm;
      logic [32:0] e;
      logic [3:0]  ctl;
      logic        src;
      int          rs1, rs2, rd;
      for (int r = 8; r < 16; r++) load_reg(r, (r == 9) ? 32'hFFFF_FFFF : (r == 10) ? 32'd0 : $urandom);
      for (int it = 0; it < 40; it++) begin
         ctl = 4'($urandom_range(0, 15));
         src = 1'($urandom_range(0, 1));
         imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         rs1 = $urandom_range(0, 15);
         rs2 = $urandom_range(0, 15);
         rd  = $urandom_range(0, 31);
         a = m_regs[rs1];
         b = src ? imm : m_regs[rs2];
         e = ref_alu(ctl, a, b);
         drive_alu(ctl, rs1, rs2, src, imm, rd, 1'b1);
         checks++;
         if (dp.Zero !== (e[31:0] == 0) || dp.Neg !== e[31] || dp.Carry !== e[32] || dp.Address !== e[31:2] || dp.WriteData !== m_regs[rs2]) begin
            errors++;
            $display("FAIL alu_rand op%h a=%h b=%h: got Z%b N%b C%b addr %h wd %h expected Z%b N%b C%b addr %h wd %h",
                     ctl, a, b, dp.Zero, dp.Neg, dp.Carry, dp.Address, dp.WriteData,
                     (e[31:0] == 0), e[31], e[32], e[31:2], m_regs[rs2]);
         end
         tick();
         if (rd != 0) m_regs[rd] = e[31:0];
         read_reg(rd, v);
         checks++; if (v !== m_regs[rd]) begin errors++; $display("FAIL alu_rand_wb x%0d: got %h expected %h", rd, v, m_regs[rd]); end
      end
   endtask

   task automatic test_writeback();
      logic [31:0] v;
      idle_in();
      dp.MemtoReg = 1'b1; dp.ReadData = 32'hA5A5_A5A5; dp.RD = 5'd4; dp.RegWrite = 1'b1;
      tick(); m_regs[4] = 32'hA5A5_A5A5;
      read_reg(4, v);
      checks++; if (v !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wb_mem: got %h expected a5a5a5a5", v); end
      idle_in();
      dp.link = 1'b1; dp.pclink = 32'h104; dp.RD = 5'd1; dp.RegWrite = 1'b1;
      tick(); m_regs[1] = 32'h104;
      read_reg(1, v);
      checks++; if (v !== 32'h104) begin errors++; $display("FAIL wb_link: got %h expected 104", v); end
      idle_in();
      dp.link = 1'b1; dp.pclink = 32'h200; dp.MemtoReg = 1'b1; dp.ReadData = 32'h1234_5678; dp.RD = 5'd12; dp.RegWrite = 1'b1;
      tick(); m_regs[12] = 32'h1234_5678;
      read_reg(12, v);
      checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL wb_priority: got %h expected 12345678", v); end
      idle_in();
      dp.MemtoReg = 1'b1; dp.ReadData = 32'hDEAD_BEEF; dp.RD = 5'd0; dp.RegWrite = 1'b1;
      tick();
      read_reg(0, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL wb_x0: got %h expected 0", v); end
      idle_in();
      dp.MemtoReg = 1'b1; dp.ReadData = 32'hDEAD_BEEF; dp.RD = 5'd4; dp.RegWrite = 1'b0;
      tick();
      read_reg(4, v);
      checks++; if (v !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wb_nowrite: got %h expected a5a5a5a5", v); end
   endtask

   task automatic test_muldiv_directed();
      logic [1:0]  ops  [4];
      logic [31:0] as   [4];
      logic [31:0] bs   [4];
      logic [31:0] exps [4];
      int busy_n, done_n, done_at;
      logic [31:0] pre_v, post_v;
      bit to;
      ops  = '{2'd0, 2'd1, 2'd2, 2'd3};
      as   = '{32'h10000, 32'h10000, 32'd100, 32'd100};
      bs   = '{32'h30000, 32'h30000, 32'd7, 32'd7};
      exps = '{32'h0, 32'h3, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         load_reg(1, as[i]);
         load_reg(2, bs[i]);
         load_reg(5, 32'h5555_0000 + 32'(i));
         run_md(ops[i], 1, 2, 5, 1'b0, 1'b0, 0, '0, busy_n, done_n, done_at, pre_v, post_v, to);
         checks++; if (to) begin errors++; $display("FAIL md_dir%0d_timeout: Busy never dropped", i); end
         checks++; if (busy_n !== 33 || done_n !== 1 || done_at !== 33) begin errors++; $display("FAIL md_dir%0d_timing: got busy %0d done %0d at %0d expected 33 1 33", i, busy_n, done_n, done_at); end
         checks++; if (pre_v !== 32'h5555_0000 + 32'(i)) begin errors++; $display("FAIL md_dir%0d_noforward: got %h expected %h", i, pre_v, 32'h5555_0000 + 32'(i)); end
         checks++; if (post_v !== exps[i]) begin errors++; $display("FAIL md_dir%0d_result: got %h expected %h", i, post_v, exps[i]); end
         m_regs[5] = exps[i];
      end
      load_reg(1, 32'd100);
      load_reg(2, 32'd0);
      run_md(2'd2, 1, 2, 5, 1'b0, 1'b0, 0, '0, busy_n, done_n, done_at, pre_v, post_v, to);
      checks++; if (to || post_v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero: got %h expected ffffffff", post_v); end
      run_md(2'd3, 1, 2, 6, 1'b0, 1'b0, 0, '0, busy_n, done_n, done_at, pre_v, post_v, to);
      checks++; if (to || post_v !== 32'd100) begin errors++; $display("FAIL remu_zero: got %h expected 64", post_v); end
      m_regs[5] = 32'hFFFF_FFFF;
      m_regs[6] = 32'd100;
   endtask

   task automatic test_muldiv_random();
      logic [1:0]  op;
      logic [31:0] a, b, e, v;
      int rd, busy_n, done_n, done_at;
      logic [31:0] pre_v, post_v;
      bit to;
      for (int it = 0; it < 8; it++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         if (op[1] && $urandom_range(0, 3) == 0) b = 0;
         else if ($urandom_range(0, 1) == 1)     b = 32'($urandom_range(1, 1000));
         else                                    b = $urandom;
         rd = $urandom_range(0, 31);
         load_reg(20, a);
         load_reg(21, b);
         e = ref_md(op, a, b);
         run_md(op, 20, 21, rd, 1'b0, 1'b0, 0, '0, busy_n, done_n, done_at, pre_v, post_v, to);
         if (rd != 0) m_regs[rd] = e;
         checks++; if (to || busy_n !== 33 || done_n !== 1) begin errors++; $display("FAIL md_rand_timing: got busy %0d done %0d expected 33 1", busy_n, done_n); end
         checks++; if (post_v !== m_regs[rd]) begin errors++; $display("FAIL md_rand op%0d a=%h b=%h: got %h expected %h", op, a, b, post_v, m_regs[rd]); end
      end
      read_reg(20, v);
      checks++; if (v !== m_regs[20]) begin errors++; $display("FAIL md_rand_x20: got %h expected %h", v, m_regs[20]); end
   endtask

   task automatic test_back_to_back();
      int busy_n, done_n, done_at;
      logic [31:0] pre_v, post_v, v;
      bit to;
      load_reg(1, 32'h1234);
      load_reg(2, 32'h10);
      load_reg(7, 32'h77);
      run_md(2'd0, 1, 2, 6, 1'b1, 1'b1, 6, 32'hDEAD, busy_n, done_n, done_at, pre_v, post_v, to);
      m_regs[6] = ref_md(2'd0, 32'h1234, 32'h10);
      checks++; if (to || busy_n !== 33 || done_n !== 1) begin errors++; $display("FAIL restart_ignored: got busy %0d done %0d expected 33 1", busy_n, done_n); end
      checks++; if (post_v !== m_regs[6]) begin errors++; $display("FAIL collide_same_rd: got %h expected %h", post_v, m_regs[6]); end
      tick();
      #1;
      checks++; if (dp.Busy !== 1'b0) begin errors++; $display("FAIL restart_late: got busy %b expected 0", dp.Busy); end
      @(negedge clock);
      read_reg(7, v);
      checks++; if (v !== 32'h77) begin errors++; $display("FAIL restart_x7: got %h expected 77", v); end
      load_reg(8, 32'h88);
      run_md(2'd1, 1, 2, 9, 1'b0, 1'b1, 8, 32'hBEEF, busy_n, done_n, done_at, pre_v, post_v, to);
      m_regs[9] = ref_md(2'd1, 32'h1234, 32'h10);
      checks++; if (to || post_v !== m_regs[9]) begin errors++; $display("FAIL collide_md_rd: got %h expected %h", post_v, m_regs[9]); end
      read_reg(8, v);
      checks++; if (v !== 32'h88) begin errors++; $display("FAIL collide_dropped: got %h expected 88", v); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset = 1'b0;
      idle_in();
      model_clear();
      test_reset();
      test_reset_midrun();
      test_alu_directed();
      test_alu_random();
      test_writeback();
      test_muldiv_directed();
      test_muldiv_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
